pulse_burst_scheduler: RTL and testbench

Shares the `my_clk`-domain pulse generator between two trigger sources: the UART receive flag and the debounced key flag. Each trigger requests a burst of `cfg_count` pulses. Every pulse is `cfg_width` cycles wide and placed at the tail of a `cfg_period`-cycle frame. Requester 0 (UART) drives `pulse_out1`; requester 1 (key) drives `pulse_out2`. The block detects trigger edges, queues one pending request per source, arbitrates round-robin, validates the configuration, and sequences the burst with a busy/done handshake.

---
 rtl/pulse_sched_pkg.sv | 17 +
 rtl/rise_edge_det.sv | 25 ++
 rtl/pulse_burst_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_pulse_burst_scheduler.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared types and defaults for the two-source pulse burst scheduler.
package pulse_sched_pkg;

  localparam int CNT_W_DEF = 25;
  localparam int CNT_N_DEF = 8;

  localparam int REQ_UART = 0;
  localparam int REQ_KEY  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Two-flop rising-edge detector for a level trigger flag.
module rise_edge_det (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic flag,
  output logic rise
);

  logic d1;
  logic d2;

  // Delay the flag by one and two cycles so a 0->1 step shows up as a one-cycle rise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= flag;
      d2 <= d1;
    end
  end

  assign rise = d1 & ~d2;

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Round-robin sharing of one pulse-burst generator between the UART and key triggers.
module pulse_burst_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CNT_N = CNT_N_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             uart_flag,
  input  logic             key_flag,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_N-1:0] cfg_count,
  input  logic             abort,
  output logic             pulse_out1,
  output logic             pulse_out2,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_N-1:0] LEFT_ONE = CNT_N'(1);

  sched_state_t     state_q, state_d;
  logic [1:0]       req_rise;
  logic [1:0]       pend_q, pend_d;
  logic             prio_key_q, prio_key_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] wid_q, wid_d;
  logic [CNT_N-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_N-1:0] left_q, left_d;
  logic             pulse1_q, pulse1_d;
  logic             pulse2_q, pulse2_d;
  logic             err_q, err_d;
  logic             pick_key;
  logic             pulse_hi;

  rise_edge_det u_uart_edge (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .flag      (uart_flag),
    .rise      (req_rise[REQ_UART])
  );

  rise_edge_det u_key_edge (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .flag      (key_flag),
    .rise      (req_rise[REQ_KEY])
  );

  // Arbitration, config check and burst sequencing; the round-robin pointer only
  // moves on a contested grant so simultaneous requests alternate between sources.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q | req_rise;
    prio_key_d = prio_key_q;
    grant_d    = grant_q;
    per_d      = per_q;
    wid_d      = wid_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    pulse1_d   = 1'b0;
    pulse2_d   = 1'b0;
    err_d      = err_q;
    pick_key   = 1'b0;
    pulse_hi   = (cnt_q >= (per_q - wid_q));

    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (|pend_q) begin
          if (&pend_q) begin
            pick_key   = prio_key_q;
            prio_key_d = ~prio_key_q;
          end else begin
            pick_key = pend_q[REQ_KEY];
          end
          if (pick_key) begin
            grant_d         = 2'b10;
            pend_d[REQ_KEY] = 1'b0;
          end else begin
            grant_d          = 2'b01;
            pend_d[REQ_UART] = 1'b0;
          end
          per_d   = cfg_period;
          wid_d   = cfg_width;
          num_d   = cfg_count;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (abort || (wid_q == '0) || (wid_q >= per_q) || (num_q == '0)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = '0;
          left_d  = num_q;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          pulse1_d = grant_q[REQ_UART] & pulse_hi;
          pulse2_d = grant_q[REQ_KEY] & pulse_hi;
          if (cnt_q == (per_q - CNT_ONE)) begin
            left_d = left_q - LEFT_ONE;
            if (left_q == LEFT_ONE) begin
              state_d = ST_DONE;
            end else begin
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_DONE: begin
        grant_d = 2'b00;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending bits, shadow config, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_q     <= 2'b00;
      prio_key_q <= 1'b0;
      grant_q    <= 2'b00;
      per_q      <= '0;
      wid_q      <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      left_q     <= '0;
      pulse1_q   <= 1'b0;
      pulse2_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      prio_key_q <= prio_key_d;
      grant_q    <= grant_d;
      per_q      <= per_d;
      wid_q      <= wid_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      pulse1_q   <= pulse1_d;
      pulse2_q   <= pulse2_d;
      err_q      <= err_d;
    end
  end

  assign pulse_out1 = pulse1_q;
  assign pulse_out2 = pulse2_q;
  assign grant      = grant_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Scoreboard bench for pulse_burst_scheduler: expected bursts are queued when
// triggers are driven, a monitor summarises each observed burst at its done strobe.
module tb_pulse_burst_scheduler;

  localparam int CW = 25;
  localparam int CN = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          uart_flag;
  logic          key_flag;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_width;
  logic [CN-1:0] cfg_count;
  logic          abort;
  logic          pulse_out1;
  logic          pulse_out2;
  logic [1:0]    grant;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [1:0] owner;
    int         n_own;
    int         n_oth;
    int         wmin;
    int         wmax;
    int         gap;
    logic       err;
    int         done_lat;
    int         rise_lat;
  } burst_t;

  burst_t exp_q[$];
  burst_t obs_q[$];
  int     gap_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int stray  = 0;

  pulse_burst_scheduler #(.CNT_W(CW), .CNT_N(CN)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .uart_flag  (uart_flag),
    .key_flag   (key_flag),
    .cfg_period (cfg_period),
    .cfg_width  (cfg_width),
    .cfg_count  (cfg_count),
    .abort      (abort),
    .pulse_out1 (pulse_out1),
    .pulse_out2 (pulse_out2),
    .grant      (grant),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Monitor: summarise each burst from grant rise to done strobe.
  int     cyc = 0;
  int     g_cyc = 0;
  int     run = 0;
  int     last_rise = 0;
  int     last_done_cyc = 0;
  logic   active = 1'b0;
  logic   prev1 = 1'b0, prev2 = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic   own, oth, p_own, p_oth;
  burst_t cur;

  always @(negedge sys_clk) begin
    cyc++;
    if (!sys_rst_n) begin
      active = 1'b0;
    end else begin
      if (!active && grant != 2'b00 && prev_grant == 2'b00) begin
        active       = 1'b1;
        cur          = '0;
        cur.owner    = grant;
        cur.rise_lat = -1;
        g_cyc        = cyc;
        run          = 0;
        last_rise    = 0;
        gap_q.push_back(cyc - last_done_cyc);
      end
      if (active) begin
        own   = cur.owner[0] ? pulse_out1 : pulse_out2;
        oth   = cur.owner[0] ? pulse_out2 : pulse_out1;
        p_own = cur.owner[0] ? prev1 : prev2;
        p_oth = cur.owner[0] ? prev2 : prev1;
        if (own && !p_own) begin
          cur.n_own = cur.n_own + 1;
          if (cur.rise_lat < 0) cur.rise_lat = cyc - g_cyc;
          else if (cur.gap == 0) cur.gap = cyc - last_rise;
          else if (cur.gap != cyc - last_rise) cur.gap = -2;
          last_rise = cyc;
          run = 0;
        end
        if (own) run++;
        if ((!own && p_own) || (own && done)) begin
          if (cur.wmin == 0 || run < cur.wmin) cur.wmin = run;
          if (run > cur.wmax) cur.wmax = run;
        end
        if (oth && !p_oth) cur.n_oth = cur.n_oth + 1;
        if (done) begin
          cur.err      = err;
          cur.done_lat = cyc - g_cyc;
          obs_q.push_back(cur);
          active        = 1'b0;
          last_done_cyc = cyc;
        end
      end else if (pulse_out1 || pulse_out2) begin
        stray++;
      end
    end
    prev1      = pulse_out1;
    prev2      = pulse_out2;
    prev_grant = grant;
  end

  function automatic burst_t exp_normal(logic [1:0] o, int p, int w, int n);
    burst_t b;
    b          = '0;
    b.owner    = o;
    b.n_own    = n;
    b.wmin     = w;
    b.wmax     = w;
    b.gap      = (n > 1) ? p : 0;
    b.err      = 1'b0;
    b.done_lat = n * p + 1;
    b.rise_lat = p - w + 2;
    return b;
  endfunction

  function automatic burst_t exp_reject(logic [1:0] o);
    burst_t b;
    b          = '0;
    b.owner    = o;
    b.err      = 1'b1;
    b.done_lat = 1;
    b.rise_lat = -1;
    return b;
  endfunction

  function automatic string fmt(burst_t b);
    return $sformatf("own=%b n=%0d/%0d w=%0d..%0d gap=%0d err=%b done@%0d rise@%0d",
                     b.owner, b.n_own, b.n_oth, b.wmin, b.wmax, b.gap, b.err,
                     b.done_lat, b.rise_lat);
  endfunction

  task automatic set_cfg(input int p, input int w, input int n);
    cfg_period = CW'(p);
    cfg_width  = CW'(w);
    cfg_count  = CN'(n);
  endtask

  task automatic fire(input logic u, input logic k);
    uart_flag = u;
    key_flag  = k;
    repeat (2) @(negedge sys_clk);
    uart_flag = 1'b0;
    key_flag  = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (grant != 2'b00) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic wait_obs(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (obs_q.size() >= k) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    gap_q.delete();
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({pulse_out1, pulse_out2, grant, busy, done, err} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got %b want 0000000",
               {pulse_out1, pulse_out2, grant, busy, done, err});
    end
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    n_cmp++;
    if ({pulse_out1, pulse_out2, grant, busy, done, err} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got %b want 0000000",
               {pulse_out1, pulse_out2, grant, busy, done, err});
    end
  endtask

  task automatic test_single_burst();
    int tp[3] = '{25, 5, 6};
    int tw[3] = '{4, 4, 1};
    int tn[3] = '{3, 2, 1};
    bit ok;
    burst_t e, o;
    for (int i = 0; i < 3; i++) begin
      set_cfg(tp[i], tw[i], tn[i]);
      exp_q.push_back(exp_normal(2'b01, tp[i], tw[i], tn[i]));
      fire(1'b1, 1'b0);
      wait_grant(ok);
      set_cfg(3, 7, 0);
      wait_obs(1, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("[TB] FAIL single_burst[%0d]: got no done want done", i);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        void'(gap_q.pop_front());
        if (o !== e) begin
          n_fail++;
          $display("[TB] FAIL single_burst[%0d]: got %s want %s", i, fmt(o), fmt(e));
        end
      end
      repeat (5) @(negedge sys_clk);
    end
  endtask

  task automatic test_reject();
    int tp[4] = '{25, 25, 25, 10};
    int tw[4] = '{25, 4, 0, 12};
    int tn[4] = '{3, 0, 2, 1};
    bit ok;
    burst_t e, o;
    for (int i = 0; i < 4; i++) begin
      set_cfg(tp[i], tw[i], tn[i]);
      exp_q.push_back(exp_reject(2'b01));
      fire(1'b1, 1'b0);
      wait_obs(1, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("[TB] FAIL reject[%0d]: got no done want done", i);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        void'(gap_q.pop_front());
        if (o !== e) begin
          n_fail++;
          $display("[TB] FAIL reject[%0d]: got %s want %s", i, fmt(o), fmt(e));
        end
      end
      repeat (5) @(negedge sys_clk);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int g;
    burst_t e, o;
    do_reset();
    set_cfg(6, 2, 2);
    for (int pair = 0; pair < 2; pair++) begin
      if (pair == 0) begin
        exp_q.push_back(exp_normal(2'b01, 6, 2, 2));
        exp_q.push_back(exp_normal(2'b10, 6, 2, 2));
      end else begin
        exp_q.push_back(exp_normal(2'b10, 6, 2, 2));
        exp_q.push_back(exp_normal(2'b01, 6, 2, 2));
      end
      fire(1'b1, 1'b1);
      wait_obs(2, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("[TB] FAIL simultaneous[%0d]: got %0d bursts want 2", pair, obs_q.size());
        exp_q.delete();
        obs_q.delete();
        gap_q.delete();
      end else begin
        for (int j = 0; j < 2; j++) begin
          e = exp_q.pop_front();
          o = obs_q.pop_front();
          g = gap_q.pop_front();
          if (j == 1) begin
            n_cmp++;
            if (g !== 2) begin
              n_fail++;
              $display("[TB] FAIL simultaneous_gap[%0d]: got %0d want 2", pair, g);
            end
          end else begin
            n_cmp++;
          end
          if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL simultaneous[%0d.%0d]: got %s want %s", pair, j, fmt(o), fmt(e));
          end
        end
      end
      repeat (5) @(negedge sys_clk);
    end
  endtask

  task automatic test_three_edges();
    bit ok;
    int g;
    burst_t e, o;
    set_cfg(25, 4, 2);
    exp_q.push_back(exp_normal(2'b01, 25, 4, 2));
    exp_q.push_back(exp_normal(2'b01, 25, 4, 2));
    fire(1'b1, 1'b0);
    wait_grant(ok);
    for (int i = 0; i < 3; i++) begin
      uart_flag = 1'b1;
      repeat (2) @(negedge sys_clk);
      uart_flag = 1'b0;
      repeat (2) @(negedge sys_clk);
    end
    wait_obs(2, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL three_edges: got %0d bursts want 2", obs_q.size());
      exp_q.delete();
      obs_q.delete();
      gap_q.delete();
    end else begin
      for (int j = 0; j < 2; j++) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        g = gap_q.pop_front();
        if (j == 1) begin
          n_cmp++;
          if (g !== 2) begin
            n_fail++;
            $display("[TB] FAIL three_edges_gap: got %0d want 2", g);
          end
        end else begin
          n_cmp++;
        end
        if (o !== e) begin
          n_fail++;
          $display("[TB] FAIL three_edges[%0d]: got %s want %s", j, fmt(o), fmt(e));
        end
      end
    end
    repeat (80) @(negedge sys_clk);
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL three_edges_extra: got %0d extra bursts want 0", obs_q.size());
      obs_q.delete();
      gap_q.delete();
    end
  endtask

  task automatic test_abort();
    bit ok;
    int rises;
    int g;
    logic prev;
    burst_t e, o, ab;
    set_cfg(10, 4, 3);
    ab          = '0;
    ab.owner    = 2'b01;
    ab.n_own    = 2;
    ab.wmin     = 1;
    ab.wmax     = 4;
    ab.gap      = 10;
    ab.err      = 1'b1;
    ab.done_lat = (10 - 4 + 2) + 10 + 1;
    ab.rise_lat = 10 - 4 + 2;
    exp_q.push_back(ab);
    exp_q.push_back(exp_normal(2'b10, 10, 4, 3));
    fire(1'b1, 1'b0);
    wait_grant(ok);
    key_flag = 1'b1;
    repeat (2) @(negedge sys_clk);
    key_flag = 1'b0;
    rises = 0;
    prev  = pulse_out1;
    for (int i = 0; i < 60 && rises < 2; i++) begin
      @(negedge sys_clk);
      if (pulse_out1 && !prev) rises++;
      prev = pulse_out1;
    end
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    n_cmp++;
    if ({pulse_out1, done, err} !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL abort_edge: got out1/done/err=%b want 011", {pulse_out1, done, err});
    end
    wait_obs(2, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL abort: got %0d bursts want 2", obs_q.size());
      exp_q.delete();
      obs_q.delete();
      gap_q.delete();
    end else begin
      for (int j = 0; j < 2; j++) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        g = gap_q.pop_front();
        if (j == 1) begin
          n_cmp++;
          if (g !== 2) begin
            n_fail++;
            $display("[TB] FAIL abort_gap: got %0d want 2", g);
          end
        end else begin
          n_cmp++;
        end
        if (o !== e) begin
          n_fail++;
          $display("[TB] FAIL abort[%0d]: got %s want %s", j, fmt(o), fmt(e));
        end
      end
    end
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_reset_mid_pulse();
    int grants;
    bit seen;
    set_cfg(10, 4, 3);
    fire(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pulse_out1) begin
        seen = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_rise: got out1=0 want 1");
    end
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pulse_out1, pulse_out2, grant, busy, done} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_async: got %b want 000000",
               {pulse_out1, pulse_out2, grant, busy, done});
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    gap_q.delete();
    grants = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (grant != 2'b00 || busy) grants++;
    end
    n_cmp++;
    if (grants !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_no_burst: got %0d busy cycles want 0", grants);
    end
  endtask

  task automatic test_idle_quiet();
    n_cmp++;
    if (stray !== 0) begin
      n_fail++;
      $display("[TB] FAIL idle_quiet: got %0d stray high samples want 0", stray);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL leftover_expect: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    uart_flag  = 1'b0;
    key_flag   = 1'b0;
    abort      = 1'b0;
    cfg_period = '0;
    cfg_width  = '0;
    cfg_count  = '0;
    test_reset();
    test_single_burst();
    test_reject();
    test_simultaneous();
    test_three_edges();
    test_abort();
    test_reset_mid_pulse();
    test_idle_quiet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
